// File: rtl/au_accum_if.sv
// Handshake bundle for au_accum: operand stream in, frame-sum stream out.
// Port summary:
//   in_vld/in_rdy/in_data/in_last : operand stream (master drives vld/data/last)
//   out_vld/out_rdy/out_sum       : frame-sum stream (master drives rdy)
//   out_ovf                       : sticky frame carry-out, only with AU_ACCUM_OVF_EN
// master = upstream/downstream environment, slave = the accumulator.
interface au_accum_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_vld;
    logic             in_rdy;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_vld;
    logic             out_rdy;
    logic [WIDTH-1:0] out_sum;
`ifdef AU_ACCUM_OVF_EN
    logic             out_ovf;
`endif

    modport master (
        output in_vld, in_data, in_last, out_rdy,
`ifdef AU_ACCUM_OVF_EN
        input  out_ovf,
`endif
        input  in_rdy, out_vld, out_sum
    );

    modport slave (
        input  in_vld, in_data, in_last, out_rdy,
`ifdef AU_ACCUM_OVF_EN
        output out_ovf,
`endif
        output in_rdy, out_vld, out_sum
    );
endinterface

// File: rtl/au_accum.sv
// Sequential multi-operand accumulator. Adds a stream of WIDTH-bit operands
// modulo 2^WIDTH and emits the frame total after COUNT operands or on in_last.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : au_accum_if.slave (operand stream in, frame-sum stream out)
// Optional feature: define AU_ACCUM_OVF_EN to add the sticky carry-out flag
// (bus.out_ovf). Without it no carry logic is built.
module au_accum #(
    parameter int WIDTH = 8,
    parameter int COUNT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    au_accum_if.slave   bus
);
    localparam int unsigned W  = (WIDTH < 1) ? 1 : WIDTH;
    localparam int unsigned C  = (COUNT < 1) ? 1 : COUNT;
    localparam int unsigned CW = (C > 1) ? $clog2(C) : 1;

    // Elaboration-time parameter legality
    if (WIDTH < 1) begin : g_bad_width
        $fatal(1, "au_accum: illegal parameter WIDTH = %0d (must be >= 1)", WIDTH);
    end
    if (COUNT < 1) begin : g_bad_count
        $fatal(1, "au_accum: illegal parameter COUNT = %0d (must be >= 1)", COUNT);
    end

    typedef enum logic {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [W-1:0]    acc;
    logic [CW-1:0]   cnt;
    logic            first;

    logic            accept_c;
    logic            eof_c;
    logic [W-1:0]    sum_c;
    logic            in_rdy_d;
    logic            out_vld_d;

`ifdef AU_ACCUM_OVF_EN
    logic            ovf_acc;
    logic            ovf_c;
    logic [W:0]      sum_ext_c;
`endif

    // Handshake decode
    always_comb begin
        accept_c = bus.in_vld && bus.in_rdy;
        eof_c    = accept_c && (bus.in_last || (cnt == CW'(C - 1)));
    end

    // Running sum; a frame's first operand ignores the stale accumulator
`ifdef AU_ACCUM_OVF_EN
    always_comb begin
        sum_ext_c = {1'b0, (first ? W'(0) : acc)} + {1'b0, bus.in_data};
        sum_c     = sum_ext_c[W-1:0];
        ovf_c     = (first ? 1'b0 : ovf_acc) | sum_ext_c[W];
    end
`else
    always_comb begin
        sum_c = (first ? W'(0) : acc) + bus.in_data;
    end
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_ACC;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_ACC: if (eof_c) state_nxt = ST_OUT;
            ST_OUT: if (bus.out_vld && bus.out_rdy) state_nxt = ST_ACC;
            default: state_nxt = ST_ACC;
        endcase
    end

    // FSM outputs, decoded from next state so the handshake flags are registered
    always_comb begin
        in_rdy_d  = 1'b0;
        out_vld_d = 1'b0;
        if (state_nxt == ST_ACC) in_rdy_d  = 1'b1;
        if (state_nxt == ST_OUT) out_vld_d = 1'b1;
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.in_rdy  <= 1'b1;
            bus.out_vld <= 1'b0;
            bus.out_sum <= '0;
            acc         <= '0;
            cnt         <= '0;
            first       <= 1'b1;
`ifdef AU_ACCUM_OVF_EN
            bus.out_ovf <= 1'b0;
            ovf_acc     <= 1'b0;
`endif
        end else begin
            bus.in_rdy  <= in_rdy_d;
            bus.out_vld <= out_vld_d;
            if (accept_c) begin
                acc <= sum_c;
`ifdef AU_ACCUM_OVF_EN
                ovf_acc <= ovf_c;
`endif
                if (eof_c) begin
                    bus.out_sum <= sum_c;
                    cnt         <= '0;
                    first       <= 1'b1;
`ifdef AU_ACCUM_OVF_EN
                    bus.out_ovf <= ovf_c;
`endif
                end else begin
                    cnt   <= cnt + CW'(1);
                    first <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_au_accum.sv
// Directed bench for au_accum: a COUNT=4 instance for the main frame tests and
// a COUNT=1 instance for the single-operand-frame case.
module tb_au_accum;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    au_accum_if #(.WIDTH(8)) b  ();
    au_accum_if #(.WIDTH(8)) b1 ();

    au_accum #(.WIDTH(8), .COUNT(4)) dut  (.clk(clk), .rst_n(rst_n), .bus(b));
    au_accum #(.WIDTH(8), .COUNT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand to the COUNT=4 instance and hold it until accepted
    task automatic send(input logic [7:0] d, input logic last);
        int waited = 0;
        b.in_vld  = 1'b1;
        b.in_data = d;
        b.in_last = last;
        while (!b.in_rdy && waited < 20) begin
            tick();
            waited++;
        end
        check("send_rdy", 32'(b.in_rdy), 32'd1);
        tick();
        b.in_vld  = 1'b0;
        b.in_last = 1'b0;
    endtask

    task automatic send1(input logic [7:0] d);
        int waited = 0;
        b1.in_vld  = 1'b1;
        b1.in_data = d;
        while (!b1.in_rdy && waited < 20) begin
            tick();
            waited++;
        end
        check("send1_rdy", 32'(b1.in_rdy), 32'd1);
        tick();
        b1.in_vld = 1'b0;
    endtask

    // Called one cycle after the last accept; completes the handshake if out_rdy=1
    task automatic expect_frame(input string tag, input logic [7:0] sum, input logic ovf);
        check({tag, "_vld"}, 32'(b.out_vld), 32'd1);
        check({tag, "_sum"}, 32'(b.out_sum), 32'(sum));
        check({tag, "_rdy_lo"}, 32'(b.in_rdy), 32'd0);
`ifdef AU_ACCUM_OVF_EN
        check({tag, "_ovf"}, 32'(b.out_ovf), 32'(ovf));
`else
        if (ovf === 1'bx) n_errors++;
`endif
        if (b.out_rdy) begin
            tick();
            check({tag, "_vld_lo"}, 32'(b.out_vld), 32'd0);
            check({tag, "_rdy_hi"}, 32'(b.in_rdy), 32'd1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        b.in_vld = 1'b0;  b.in_data = '0;  b.in_last = 1'b0;  b.out_rdy = 1'b1;
        b1.in_vld = 1'b0; b1.in_data = '0; b1.in_last = 1'b0; b1.out_rdy = 1'b1;

        // Reset state
        tick();
        tick();
        check("rst_rdy", 32'(b.in_rdy), 32'd1);
        check("rst_vld", 32'(b.out_vld), 32'd0);
        check("rst_sum", 32'(b.out_sum), 32'd0);
        rst_n = 1'b1;

        // Basic frame, back-to-back
        send(8'd10, 1'b0); send(8'd20, 1'b0); send(8'd30, 1'b0); send(8'd40, 1'b0);
        expect_frame("basic", 8'd100, 1'b0);

        // Wrap-around: 200+100 = 300 -> 44 with carry
        send(8'd200, 1'b0); send(8'd100, 1'b0); send(8'd0, 1'b0); send(8'd0, 1'b0);
        expect_frame("wrap", 8'd44, 1'b1);
        send(8'd1, 1'b0); send(8'd1, 1'b0); send(8'd1, 1'b0); send(8'd1, 1'b0);
        expect_frame("after_wrap", 8'd4, 1'b0);

        // Early termination, then full frame confirms counter cleared
        send(8'd5, 1'b0); send(8'd7, 1'b1);
        expect_frame("early", 8'd12, 1'b0);
        send(8'd1, 1'b0); send(8'd2, 1'b0); send(8'd3, 1'b0); send(8'd4, 1'b0);
        expect_frame("after_early", 8'd10, 1'b0);

        // Backpressure with a stray operand offered during OUT
        b.out_rdy = 1'b0;
        send(8'd1, 1'b0); send(8'd2, 1'b0); send(8'd3, 1'b0); send(8'd4, 1'b0);
        expect_frame("bp_first", 8'd10, 1'b0);
        b.in_vld = 1'b1; b.in_data = 8'd99;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_vld", 32'(b.out_vld), 32'd1);
            check("bp_sum", 32'(b.out_sum), 32'd10);
            check("bp_rdy", 32'(b.in_rdy), 32'd0);
        end
        b.in_vld = 1'b0;
        b.out_rdy = 1'b1;
        tick();
        check("bp_release_vld", 32'(b.out_vld), 32'd0);
        check("bp_release_rdy", 32'(b.in_rdy), 32'd1);
        send(8'd1, 1'b0); send(8'd1, 1'b0); send(8'd1, 1'b0); send(8'd1, 1'b0);
        expect_frame("after_bp", 8'd4, 1'b0);

        // Reset mid-frame discards 50+60
        send(8'd50, 1'b0); send(8'd60, 1'b0);
        rst_n = 1'b0;
        tick();
        check("mid_rst_rdy", 32'(b.in_rdy), 32'd1);
        check("mid_rst_vld", 32'(b.out_vld), 32'd0);
        check("mid_rst_sum", 32'(b.out_sum), 32'd0);
`ifdef AU_ACCUM_OVF_EN
        check("mid_rst_ovf", 32'(b.out_ovf), 32'd0);
`endif
        rst_n = 1'b1;
        send(8'd1, 1'b0); send(8'd2, 1'b0); send(8'd3, 1'b0); send(8'd4, 1'b0);
        expect_frame("after_rst", 8'd10, 1'b0);

        // Sparse input: one idle cycle between operands
        send(8'd3, 1'b0); tick();
        send(8'd5, 1'b0); tick();
        send(8'd7, 1'b0); tick();
        send(8'd9, 1'b0);
        expect_frame("sparse", 8'd24, 1'b0);

        // COUNT=1 instance: every operand is a frame
        send1(8'd7);
        check("c1_a_vld", 32'(b1.out_vld), 32'd1);
        check("c1_a_sum", 32'(b1.out_sum), 32'd7);
        check("c1_a_rdy", 32'(b1.in_rdy), 32'd0);
        tick();
        check("c1_a_rdy_hi", 32'(b1.in_rdy), 32'd1);
        send1(8'd255);
        check("c1_b_vld", 32'(b1.out_vld), 32'd1);
        check("c1_b_sum", 32'(b1.out_sum), 32'd255);
        tick();
        check("c1_b_vld_lo", 32'(b1.out_vld), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
